// File: rtl/bram_dma_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bram_dma_pkg
// Purpose  : Shared types for the BRAM DMA controller: FSM state encoding and
//            transfer mode encoding.
// Revision : 1.0 - initial release
// ============================================================================
package bram_dma_pkg;

  // Controller sequencing states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Transfer kind: COPY moves words A->B, FILL writes a constant pattern.
  typedef enum logic {
    COPY = 1'b0,
    FILL = 1'b1
  } mode_e;

endpackage
`default_nettype wire

// File: rtl/bram_dma_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bram_dma_ctrl
// Purpose  : Dual-port BRAM DMA sequencer. COPY reads through port A and
//            writes the registered read data through port B one cycle later;
//            FILL writes a captured pattern through port B. Addresses wrap
//            modulo the RAM depth. Forward-overlapping copies and oversize
//            lengths are rejected with a one-cycle err_o pulse.
// Config   : BRAM_DMA_FILL_EN - when defined, enables FILL mode; otherwise
//            mode_i and fill_i are ignored and every start is a COPY.
// Revision : 1.0 - initial release
// ============================================================================
module bram_dma_ctrl
  import bram_dma_pkg::*;
#(
  parameter int RAM_WIDTH     = 8,
  parameter int RAM_ADDR_BITS = 10
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic                     mode_i,
  input  logic [RAM_ADDR_BITS-1:0] src_i,
  input  logic [RAM_ADDR_BITS-1:0] dst_i,
  input  logic [RAM_ADDR_BITS:0]   len_i,
  input  logic [RAM_WIDTH-1:0]     fill_i,
  input  logic                     abort_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o,
  output logic                     en_a_o,
  output logic                     we_a_o,
  output logic [RAM_ADDR_BITS-1:0] addr_a_o,
  input  logic [RAM_WIDTH-1:0]     rdata_a_i,
  output logic                     en_b_o,
  output logic                     we_b_o,
  output logic [RAM_ADDR_BITS-1:0] addr_b_o,
  output logic [RAM_WIDTH-1:0]     wdata_b_o
);

  state_e                   state_q;
  logic                     en_a_q;
  logic [RAM_ADDR_BITS-1:0] addr_a_q;
  logic                     en_b_q;
  logic [RAM_ADDR_BITS-1:0] addr_b_q;
  logic [RAM_ADDR_BITS:0]   cnt_q;     // accesses still to issue after the current one
  logic                     busy_q;
  logic                     done_q;
  logic                     err_q;

  logic [RAM_ADDR_BITS-1:0] w_gap;
  logic                     w_len_bad;
  logic                     w_overlap;
  logic                     w_is_fill;
  logic                     w_run_fill;
  logic                     w_reject;
  logic                     w_accept;
  logic [RAM_WIDTH-1:0]     w_wdata;

  // Length above depth: MSB set with any lower bit set.
  assign w_len_bad = len_i[RAM_ADDR_BITS] & (|len_i[RAM_ADDR_BITS-1:0]);
  // A copy whose destination lies 1..L-1 words ahead of its source would
  // overwrite words before they are read.
  assign w_gap     = dst_i - src_i;
  assign w_overlap = (w_gap != '0) && ({1'b0, w_gap} < len_i);
  assign w_reject  = w_len_bad | (~w_is_fill & w_overlap);
  assign w_accept  = (state_q == IDLE) && start_i && !w_reject && (len_i != '0);

`ifdef BRAM_DMA_FILL_EN
  mode_e                mode_q;
  logic [RAM_WIDTH-1:0] fill_q;

  // Capture transfer kind and pattern when a start is accepted.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mode_q <= COPY;
      fill_q <= '0;
    end else if (w_accept) begin
      mode_q <= w_is_fill ? FILL : COPY;
      fill_q <= fill_i;
    end
  end

  assign w_is_fill  = mode_i;
  assign w_run_fill = (mode_q == FILL);
  assign w_wdata    = w_run_fill ? fill_q : rdata_a_i;
`else
  logic w_unused_cfg;
  assign w_unused_cfg = ^{mode_i, fill_i};
  assign w_is_fill    = 1'b0;
  assign w_run_fill   = 1'b0;
  assign w_wdata      = rdata_a_i;
`endif

  // Sequencer FSM with registered port controls and status pulses.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      en_a_q   <= 1'b0;
      addr_a_q <= '0;
      en_b_q   <= 1'b0;
      addr_b_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            if (w_reject) begin
              err_q <= 1'b1;
            end else if (len_i == '0) begin
              done_q <= 1'b1;
            end else begin
              state_q  <= RUN;
              busy_q   <= 1'b1;
              addr_b_q <= dst_i;
              cnt_q    <= len_i - (RAM_ADDR_BITS+1)'(1);
              if (w_is_fill) begin
                en_b_q <= 1'b1;
              end else begin
                en_a_q   <= 1'b1;
                addr_a_q <= src_i;
              end
            end
          end
        end
        RUN: begin
          if (w_run_fill) begin
            if (abort_i || cnt_q == '0) begin
              en_b_q  <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= IDLE;
            end else begin
              addr_b_q <= addr_b_q + RAM_ADDR_BITS'(1);
              cnt_q    <= cnt_q - (RAM_ADDR_BITS+1)'(1);
            end
          end else begin
            // Every RUN cycle of a copy has a read whose data lands next cycle.
            en_b_q <= 1'b1;
            if (en_b_q) begin
              addr_b_q <= addr_b_q + RAM_ADDR_BITS'(1);
            end
            if (abort_i || cnt_q == '0) begin
              en_a_q  <= 1'b0;
              state_q <= DRAIN;
            end else begin
              addr_a_q <= addr_a_q + RAM_ADDR_BITS'(1);
              cnt_q    <= cnt_q - (RAM_ADDR_BITS+1)'(1);
            end
          end
        end
        DRAIN: begin
          en_b_q  <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign err_o     = err_q;
  assign en_a_o    = en_a_q;
  assign we_a_o    = 1'b0;
  assign addr_a_o  = addr_a_q;
  assign en_b_o    = en_b_q;
  assign we_b_o    = en_b_q;
  assign addr_b_o  = addr_b_q;
  assign wdata_b_o = en_b_q ? w_wdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_bram_dma_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_bram_dma_ctrl
// Purpose  : Self-checking bench for bram_dma_ctrl (4-bit address, 8-bit
//            data) paired with a true dual-port BRAM model. Table-driven
//            transfers plus hand-written reset-during-transfer sequence.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bram_dma_ctrl;

  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int WIN   = 22;

  logic          clk;
  logic          rst;
  logic          start;
  logic          mode;
  logic [AW-1:0] src;
  logic [AW-1:0] dst;
  logic [AW:0]   len;
  logic [DW-1:0] fill;
  logic          abort;
  logic          busy;
  logic          done;
  logic          err;
  logic          en_a;
  logic          we_a;
  logic [AW-1:0] addr_a;
  logic [DW-1:0] rdata_a;
  logic          en_b;
  logic          we_b;
  logic [AW-1:0] addr_b;
  logic [DW-1:0] wdata_b;

  logic          tb_we;
  logic [AW-1:0] tb_addr;
  logic [DW-1:0] tb_wdata;
  logic [DW-1:0] mem     [DEPTH];
  logic [DW-1:0] exp_mem [DEPTH];

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit            mode;
    logic [AW-1:0] src;
    logic [AW-1:0] dst;
    logic [AW:0]   len;
    logic [DW-1:0] fill;
    int            abort_at;
    bit            restart;
    int            exp_err_c;
    int            exp_done_c;
    int            exp_busy;
    int            exp_nwr;
  } vec_t;

  vec_t vecs[$];

  bram_dma_ctrl #(
    .RAM_WIDTH     (DW),
    .RAM_ADDR_BITS (AW)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .start_i   (start),
    .mode_i    (mode),
    .src_i     (src),
    .dst_i     (dst),
    .len_i     (len),
    .fill_i    (fill),
    .abort_i   (abort),
    .busy_o    (busy),
    .done_o    (done),
    .err_o     (err),
    .en_a_o    (en_a),
    .we_a_o    (we_a),
    .addr_a_o  (addr_a),
    .rdata_a_i (rdata_a),
    .en_b_o    (en_b),
    .we_b_o    (we_b),
    .addr_b_o  (addr_b),
    .wdata_b_o (wdata_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Dual-port BRAM: registered port-A read, port-B write, bench preload port.
  always @(posedge clk) begin
    if (en_a) rdata_a <= mem[addr_a];
    if (en_b && we_b) mem[addr_b] <= wdata_b;
    else if (tb_we) mem[tb_addr] <= tb_wdata;
  end

  function automatic vec_t mk(bit m, int s, int d, int l, int f, int ab, bit rs,
                              int e_err, int e_done, int e_busy, int e_nwr);
    vec_t v;
    v.mode       = m;
    v.src        = AW'(s);
    v.dst        = AW'(d);
    v.len        = (AW+1)'(l);
    v.fill       = DW'(f);
    v.abort_at   = ab;
    v.restart    = rs;
    v.exp_err_c  = e_err;
    v.exp_done_c = e_done;
    v.exp_busy   = e_busy;
    v.exp_nwr    = e_nwr;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic mem_check(input string name);
    int bad;
    int first;
    bad   = 0;
    first = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (mem[i] !== exp_mem[i]) begin
        if (bad == 0) first = i;
        bad++;
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s: %0d words differ, first at %0d actual %0h required %0h",
               name, bad, first, mem[first], exp_mem[first]);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    bit            is_fill;
    int            nrd;
    int            busy_n, done_n, err_n, done_c, err_c, wr_n, bad_c;
    bit            acc_ok;
    bit            ea, eb;
    logic [AW-1:0] a;
    logic [DW-1:0] ew;
`ifdef BRAM_DMA_FILL_EN
    is_fill = v.mode;
`else
    is_fill = 1'b0;
`endif
    // Expected memory after the transfer (reads precede writes for accepted copies).
    for (int k = 0; k < v.exp_nwr; k++) begin
      a = AW'(int'(v.dst) + k);
      exp_mem[a] = is_fill ? v.fill : exp_mem[AW'(int'(v.src) + k)];
    end
    nrd = is_fill ? 0 : v.exp_nwr;
    busy_n = 0; done_n = 0; err_n = 0; done_c = 0; err_c = 0; wr_n = 0;
    bad_c = 0; acc_ok = 1'b1;

    @(negedge clk);
    start = 1'b1; mode = v.mode; src = v.src; dst = v.dst; len = v.len; fill = v.fill;
    for (int c = 1; c <= WIN; c++) begin
      @(negedge clk);
      if (busy === 1'b1) busy_n++;
      if (done === 1'b1) begin done_n++; if (done_c == 0) done_c = c; end
      if (err === 1'b1) begin err_n++; if (err_c == 0) err_c = c; end
      if (en_b === 1'b1 && we_b === 1'b1) wr_n++;
      ea = (c <= nrd);
      if (is_fill) begin
        eb = (c <= v.exp_nwr);
        a  = AW'(int'(v.dst) + c - 1);
      end else begin
        eb = (c >= 2) && (c <= v.exp_nwr + 1);
        a  = AW'(int'(v.dst) + c - 2);
      end
      ew = exp_mem[a];
      if (en_a !== ea || we_a !== 1'b0 || en_b !== eb || we_b !== eb ||
          (ea && addr_a !== AW'(int'(v.src) + c - 1)) ||
          (eb && (addr_b !== a || wdata_b !== ew))) begin
        if (acc_ok) bad_c = c;
        acc_ok = 1'b0;
      end
      if (c == 1) start = 1'b0;
      if (v.restart && c == 2) begin start = 1'b1; len = '0; end
      if (v.restart && c == 3) start = 1'b0;
      abort = (c == v.abort_at);
    end
    abort = 1'b0;

    check($sformatf("v%0d err_cycle", idx),   err_c,  v.exp_err_c);
    check($sformatf("v%0d err_count", idx),   err_n,  (v.exp_err_c != 0) ? 1 : 0);
    check($sformatf("v%0d done_cycle", idx),  done_c, v.exp_done_c);
    check($sformatf("v%0d done_count", idx),  done_n, (v.exp_done_c != 0) ? 1 : 0);
    check($sformatf("v%0d busy_cycles", idx), busy_n, v.exp_busy);
    check($sformatf("v%0d writes", idx),      wr_n,   v.exp_nwr);
    check($sformatf("v%0d access_ok (first bad cycle %0d)", idx, bad_c), acc_ok, 1);
    mem_check($sformatf("v%0d mem_image", idx));
  endtask

  initial begin
    int wr_n;
    int done_n;

    rst = 1'b1; start = 1'b0; mode = 1'b0; src = '0; dst = '0; len = '0;
    fill = '0; abort = 1'b0; tb_we = 1'b0; tb_addr = '0; tb_wdata = '0;

    //            mode src dst len fill abort rst  err done busy nwr
    vecs.push_back(mk(0,  0,  8,  4, 0,    0, 0,   0,  6,  5,  4)); // basic copy
    vecs.push_back(mk(0, 14,  2,  4, 0,    0, 0,   0,  6,  5,  4)); // source wraps
    vecs.push_back(mk(0,  3,  5,  4, 0,    0, 0,   1,  0,  0,  0)); // forward overlap
    vecs.push_back(mk(0,  0,  0, 17, 0,    0, 0,   1,  0,  0,  0)); // too long
    vecs.push_back(mk(0,  0,  8,  0, 0,    0, 0,   0,  1,  0,  0)); // zero length
    vecs.push_back(mk(0,  5,  5, 16, 0,    0, 0,   0, 18, 17, 16)); // full depth, in place
    vecs.push_back(mk(0,  9,  1, 16, 0,    0, 0,   1,  0,  0,  0)); // full depth overlap
    vecs.push_back(mk(0,  6,  4,  3, 0,    0, 0,   0,  5,  4,  3)); // backward overlap ok
    vecs.push_back(mk(0,  3,  4,  1, 0,    0, 0,   0,  3,  2,  1)); // single word
    vecs.push_back(mk(0,  0,  8,  8, 0,    3, 0,   0,  5,  4,  3)); // abort at T+3
    vecs.push_back(mk(0,  0,  8,  4, 0,    0, 1,   0,  6,  5,  4)); // start while busy
    vecs.push_back(mk(0,  3,  4,  2, 0,    0, 0,   1,  0,  0,  0)); // gap 1 < len 2
    vecs.push_back(mk(0,  3,  5,  2, 0,    0, 0,   0,  4,  3,  2)); // gap == len
`ifdef BRAM_DMA_FILL_EN
    vecs.push_back(mk(1,  0, 15,  3, 8'hA5, 0, 0,  0,  4,  3,  3)); // fill wraps
    vecs.push_back(mk(1,  3,  5,  4, 8'h3C, 0, 0,  0,  5,  4,  4)); // no overlap check
    vecs.push_back(mk(1,  0,  0,  5, 8'hC3, 2, 0,  0,  3,  2,  2)); // fill abort
    vecs.push_back(mk(1,  0,  0, 17, 8'h11, 0, 0,  1,  0,  0,  0)); // fill too long
`else
    vecs.push_back(mk(1,  0,  8,  2, 8'hA5, 0, 0,  0,  4,  3,  2)); // mode ignored
    vecs.push_back(mk(1,  3,  5,  4, 8'hA5, 0, 0,  1,  0,  0,  0)); // treated as copy
`endif

    repeat (3) @(negedge clk);
    check("reset_outputs",
          {busy, done, err, en_a, we_a, addr_a, en_b, we_b, addr_b, wdata_b}, 64'd0);
    rst = 1'b0;

    // Preload memory: words 0..3 = 11,22,33,44, the rest 0x50+i.
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      tb_we    = 1'b1;
      tb_addr  = AW'(i);
      tb_wdata = (i < 4) ? DW'(11 * (i + 1)) : DW'(8'h50 + i);
      exp_mem[i] = tb_wdata;
    end
    @(negedge clk);
    tb_we = 1'b0;
    mem_check("preload");

    for (int i = 0; i < vecs.size(); i++) run_vec(i, vecs[i]);

    // Reset sampled at edge T+3 of an 8-word copy: two writes land, then silence.
    exp_mem[12] = exp_mem[0];
    exp_mem[13] = exp_mem[1];
    wr_n   = 0;
    done_n = 0;
    @(negedge clk);
    start = 1'b1; mode = 1'b0; src = 4'd0; dst = 4'd12; len = 5'd8;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (en_b === 1'b1 && we_b === 1'b1) wr_n++;
      if (done === 1'b1) done_n++;
      if (c == 4)
        check("rst_outputs_T4",
              {busy, done, err, en_a, we_a, addr_a, en_b, we_b, addr_b, wdata_b}, 64'd0);
      if (c == 1) start = 1'b0;
      if (c == 3) rst = 1'b1;
      if (c == 4) rst = 1'b0;
    end
    check("rst_writes", wr_n, 2);
    check("rst_no_done", done_n, 0);
    mem_check("rst_mem_image");

    // Normal operation resumes after the mid-transfer reset.
    run_vec(100, mk(0, 8, 14, 2, 0, 0, 0, 0, 4, 3, 2));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bram_dma_ctrl.md
BRAM_DMA_CTRL -- requirements
Module: bram_dma_ctrl

Interface
REQ-001 SHALL have parameter RAM_WIDTH, default 8, meaning data word width.
REQ-002 SHALL have parameter RAM_ADDR_BITS, default 10, meaning address width; depth = 2**RAM_ADDR_BITS.
REQ-003 SHALL have ports, one per line: name, direction, width, meaning.
- clk_i  in  1  single clock; all logic on posedge.
- rst_i  in  1  synchronous, active-high reset.
- start_i  in  1  start request, sampled only in IDLE.
- mode_i  in  1  0 = COPY, 1 = FILL.
- src_i  in  RAM_ADDR_BITS  copy source base.
- dst_i  in  RAM_ADDR_BITS  destination base.
- len_i  in  RAM_ADDR_BITS+1  word count, 0..depth.
- fill_i  in  RAM_WIDTH  fill pattern.
- abort_i  in  1  stop issuing new accesses.
- busy_o  out  1  operation in progress.
- done_o  out  1  one-cycle completion pulse.
- err_o  out  1  one-cycle rejection pulse.
- en_a_o / we_a_o  out  1 / 1  BRAM port A enable / write enable; we_a_o is constant 0.
- addr_a_o  out  RAM_ADDR_BITS  port A address.
- rdata_a_i  in  RAM_WIDTH  port A registered read data, 1-cycle latency.
- en_b_o / we_b_o  out  1 / 1  BRAM port B enable / write enable.
- addr_b_o  out  RAM_ADDR_BITS  port B address.
- wdata_b_o  out  RAM_WIDTH  port B write data.

Function
REQ-004 SHALL implement FSM states IDLE, RUN, DRAIN.
- IDLE->RUN on accepted start.
- RUN->DRAIN after the last port-A read (COPY), or RUN->IDLE after the last write (FILL).
- DRAIN->IDLE after the last write.
REQ-005 SHALL sample start_i only in IDLE; start_i while busy_o=1 is ignored.
REQ-006 SHALL, for an accepted COPY start sampled at edge T, length L:
- assert en_a_o with addr_a_o = src+k in cycle T+1+k, k = 0..L-1.
- assert en_b_o = we_b_o = 1 with addr_b_o = dst+k and wdata_b_o = rdata_a_i in cycle T+2+k.
REQ-007 SHALL, for FILL, write fill_i (captured at T) to dst+k in cycle T+1+k with port A idle.
REQ-008 SHALL compute all addresses modulo 2**RAM_ADDR_BITS (wrap-around, no error).
REQ-009 SHALL hold busy_o=1 from T+1 through the last write cycle, then pulse done_o for exactly one cycle the cycle after the last write.
REQ-010 SHALL, for len_i = 0, issue no accesses and pulse done_o in T+1; busy_o stays 0.
REQ-011 SHALL reject the start, pulse err_o in T+1, issue no accesses and remain in IDLE when either:
- len_i > 2**RAM_ADDR_BITS, or
- COPY with (dst-src) mod depth in 1..L-1 (forward-overlap hazard).
REQ-012 SHALL, on abort_i=1 in RUN, issue no further port-A reads or FILL writes, complete any in-flight COPY write, then pulse done_o.
REQ-013 SHALL drive en_a_o, en_b_o and we_b_o to 0 in every cycle with no scheduled access.

Reset
REQ-014 SHALL, on rst_i=1 at a clock edge, enter IDLE with all outputs 0 in the following cycle, from any state.
REQ-015 SHALL not perform any write in the cycle after a reset edge; an in-flight write is discarded.

Configuration
REQ-016 SHALL compile FILL support only when BRAM_DMA_FILL_EN is defined.
REQ-017 SHALL, without BRAM_DMA_FILL_EN, ignore mode_i and fill_i and treat every start as COPY.

Structure
REQ-018 SHALL place the state enum (IDLE/RUN/DRAIN) and the mode enum (COPY/FILL) in package bram_dma_pkg.
REQ-019 SHALL be a single module with no sub-module; the BRAM is external, connected at the next level.

Verification (RAM_ADDR_BITS=4, RAM_WIDTH=8, bench pairs the block with a true dual-port BRAM)
REQ-020 SHALL cover COPY src=0, dst=8, len=4, with mem[0..3]=11,22,33,44:
- mem[8..11]=11,22,33,44.
- busy_o high 5 cycles; done_o at T+6.
REQ-021 SHALL cover COPY src=14, dst=2, len=4: mem[14,15,0,1] copied to mem[2..5] (wrap).
REQ-022 SHALL cover FILL dst=15, len=3, fill=0xA5: mem[15,0,1]=0xA5; done_o at T+4.
REQ-023 SHALL cover overlap and length rejection:
- COPY src=3, dst=5, len=4 -> err_o pulse at T+1, no writes.
- len_i=17 -> err_o.
- len_i=0 -> done_o at T+1.
REQ-024 SHALL cover abort and reset during operation:
- abort_i in RUN of COPY len=8 asserted at T+3 -> writes stop after dst+2, one done_o.
- rst_i at T+3 -> outputs 0 at T+4, no write at T+4.
